// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
package ripple_carry_adder_pkg;

  localparam int unsigned RCA_DEFAULT_WIDTH = 4;

endpackage : ripple_carry_adder_pkg

// File: rtl/full_adder.sv
// Single-bit full adder: one stage of the ripple carry chain.
module full_adder (
  input  logic i_dummy_unused_never,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_prop;

  assign w_prop = a ^ b;
  assign s      = w_prop ^ cin;
  assign cout   = (a & b) | (cin & w_prop);

  logic w_unused;
  assign w_unused = i_dummy_unused_never;

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder with combinational sum/carry/overflow
// and a one-cycle registered copy qualified by a valid flag.
module ripple_carry_adder
  import ripple_carry_adder_pkg::*;
#(
  parameter int unsigned WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             out_valid
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] r_sum_q;
  logic             r_cout_q;
  logic             r_ovf_q;
  logic             r_out_valid;

  assign w_carry[0] = cin;

  // Carry ripples stage to stage; no lookahead.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : gen_stage
    full_adder u_fa (
      .i_dummy_unused_never (1'b0),
      .a                    (a[i]),
      .b                    (b[i]),
      .cin                  (w_carry[i]),
      .s                    (sum[i]),
      .cout                 (w_carry[i+1])
    );
  end

  assign cout = w_carry[WIDTH];
  assign ovf  = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  // Result register holds when no new input is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_q     <= '0;
      r_cout_q    <= 1'b0;
      r_ovf_q     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum_q  <= sum;
        r_cout_q <= cout;
        r_ovf_q  <= ovf;
      end
    end
  end

  assign sum_q     = r_sum_q;
  assign cout_q    = r_cout_q;
  assign ovf_q     = r_ovf_q;
  assign out_valid = r_out_valid;

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// Directed and exhaustive bench for the 4-bit ripple-carry adder.
module tb_ripple_carry_adder;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         in_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [W-1:0] sum_q;
  logic         cout_q;
  logic         ovf_q;
  logic         out_valid;

  int unsigned n_tests;
  int unsigned n_fail;

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .sum_q     (sum_q),
    .cout_q    (cout_q),
    .ovf_q     (ovf_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply operands, let the chain settle, compare {ovf,cout,sum}.
  task automatic comb_vec(input string tag, input logic [3:0] va, input logic [3:0] vb,
                          input logic vc, input logic [3:0] es, input logic ec, input logic eo);
    a   = va;
    b   = vb;
    cin = vc;
    #1;
    check(tag, 32'({ovf, cout, sum}), 32'({eo, ec, es}));
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    in_valid = 1'b0;

    #1 rst = 1'b1;
    #2;
    check("reset_regs", 32'({ovf_q, cout_q, out_valid, sum_q}), 32'h0);

    @(negedge clk);
    rst = 1'b0;

    // Zero vector, then its capture
    comb_vec("zero", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("zero_q", 32'({ovf_q, cout_q, out_valid, sum_q}), 32'({1'b0, 1'b0, 1'b1, 4'b0000}));

    @(negedge clk);
    in_valid = 1'b0;
    comb_vec("1+2",       4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0);
    comb_vec("3+5_ovf",   4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, 1'b1);
    comb_vec("6+9",       4'b0110, 4'b1001, 1'b0, 4'b1111, 1'b0, 1'b0);
    comb_vec("f+f",       4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0);
    comb_vec("f+0+1",     4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
    comb_vec("f+f+1",     4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
    comb_vec("7+1_ovf",   4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
    comb_vec("8+8_ovf",   4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);

    // Single valid pulse, then hold
    @(negedge clk);
    a = 4'b0011; b = 4'b0101; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    check("pulse_q", 32'({ovf_q, cout_q, out_valid, sum_q}), 32'({1'b1, 1'b0, 1'b1, 4'b1000}));
    @(negedge clk);
    a = 4'b0001; b = 4'b0001; in_valid = 1'b0;
    @(posedge clk); #1;
    check("hold1_q", 32'({ovf_q, cout_q, out_valid, sum_q}), 32'({1'b1, 1'b0, 1'b0, 4'b1000}));
    @(posedge clk); #1;
    check("hold2_q", 32'({ovf_q, cout_q, out_valid, sum_q}), 32'({1'b1, 1'b0, 1'b0, 4'b1000}));

    // Reset between edges while a result is valid
    @(negedge clk);
    a = 4'b1111; b = 4'b1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_q", 32'({ovf_q, cout_q, out_valid, sum_q}), 32'({1'b0, 1'b1, 1'b1, 4'b1110}));
    #2 rst = 1'b1;
    #1;
    check("async_rst_q", 32'({ovf_q, cout_q, out_valid, sum_q}), 32'h0);
    comb_vec("comb_in_rst", 4'b0010, 4'b0001, 1'b0, 4'b0011, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("rst_held_q", 32'({ovf_q, cout_q, out_valid, sum_q}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    a = 4'b0110; b = 4'b0001; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    check("post_rst_q", 32'({ovf_q, cout_q, out_valid, sum_q}), 32'({1'b1, 1'b0, 1'b1, 4'b1000}));
    @(negedge clk);
    in_valid = 1'b0;

    // Exhaustive sweep against a+b+cin
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          logic [4:0] gold;
          logic       govf;
          a   = 4'(ia);
          b   = 4'(ib);
          cin = 1'(ic);
          gold = 5'(ia) + 5'(ib) + 5'(ic);
          govf = (a[3] == b[3]) && (gold[3] != a[3]);
          #1;
          check($sformatf("sweep_%0d_%0d_%0d", ia, ib, ic),
                32'({ovf, cout, sum}), 32'({govf, gold}));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ripple_carry_adder
